// File: rtl/mtrx_seq_pkg.sv
// Shared types, parameter defaults and slot-index helpers for the matrix stream sequencer.
package mtrx_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  localparam int unsigned MtxWDefault  = 256;
  localparam int unsigned NMtxDefault  = 6;
  localparam int unsigned DwellDefault = 7;
  localparam int unsigned FcntWDefault = 16;

  // matrixState is 4 bits wide: 0 idle, 1..14 slots, 15 done at the largest N_MTX.
  localparam int unsigned SlotW  = 4;
  localparam int unsigned DwellW = 8;

  typedef logic [SlotW-1:0]  slot_idx_t;
  typedef logic [DwellW-1:0] dwell_t;

  function automatic slot_idx_t idle_idx();
    return slot_idx_t'(0);
  endfunction

  function automatic slot_idx_t done_idx(input int unsigned n_mtx);
    return slot_idx_t'(n_mtx + 1);
  endfunction

endpackage

// File: rtl/mtrx_stream_seq_if.sv
// Control/data bundle between a frame source (master) and the sequencer (slave).
interface mtrx_stream_seq_if #(
  parameter int unsigned MTX_W  = mtrx_seq_pkg::MtxWDefault,
  parameter int unsigned N_MTX  = mtrx_seq_pkg::NMtxDefault,
  parameter int unsigned FCNT_W = mtrx_seq_pkg::FcntWDefault
);

  logic                   CPUvalid;
  logic                   mode;
  logic                   loop;
  logic [N_MTX*MTX_W-1:0] mtxIn;
  logic                   mtrxReady;
  logic [3:0]             matrixState;
  logic [MTX_W-1:0]       mtrxOut;
  logic                   mtrxValid;
  logic                   frameDone;
  logic [FCNT_W-1:0]      frameCnt;

  modport master (
    output CPUvalid, mode, loop, mtxIn, mtrxReady,
    input  matrixState, mtrxOut, mtrxValid, frameDone, frameCnt
  );

  modport slave (
    input  CPUvalid, mode, loop, mtxIn, mtrxReady,
    output matrixState, mtrxOut, mtrxValid, frameDone, frameCnt
  );

endinterface

// File: rtl/mtrx_slot_mux.sv
// N:1 select of one word from a flattened bus; slot indices are 1-based, output is 0 when disabled.
module mtrx_slot_mux #(
  parameter int unsigned Width    = 256,
  parameter int unsigned Count    = 6,
  parameter int unsigned SelWidth = 4
) (
  input  logic [Count*Width-1:0] slots,
  input  logic [SelWidth-1:0]    sel,
  input  logic                   en,
  output logic [Width-1:0]       word
);

  always_comb begin
    word = '0;
    for (int unsigned k = 1; k <= Count; k++) begin
      if (en && (sel == SelWidth'(k))) begin
        word = slots[k*Width-1 -: Width];
      end
    end
  end

endmodule

// File: rtl/mtrx_stream_seq.sv
// Frame sequencer: streams N_MTX matrix slots per frame, timed-dwell or valid/ready paced.
module mtrx_stream_seq
  import mtrx_seq_pkg::*;
#(
  parameter int unsigned MTX_W  = MtxWDefault,
  parameter int unsigned N_MTX  = NMtxDefault,
  parameter int unsigned DWELL  = DwellDefault,
  parameter int unsigned FCNT_W = FcntWDefault
) (
  input logic              CLK,
  input logic              rst,
  mtrx_stream_seq_if.slave bus
);

  localparam slot_idx_t FirstIdx  = slot_idx_t'(1);
  localparam slot_idx_t LastIdx   = slot_idx_t'(N_MTX);
  localparam slot_idx_t DoneIdx   = done_idx(N_MTX);
  localparam dwell_t    DwellLast = dwell_t'(DWELL - 1);

  seq_state_e        state_q;
  slot_idx_t         slot_q;
  dwell_t            dwell_q;
  logic              mode_q;
  logic              frame_done_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic sending;
  logic advance;

  assign sending = (state_q == StSend);

  // Mode is the latched copy, so toggling the input mid-frame cannot change pacing.
  always_comb begin
    advance = 1'b0;
    if (sending) begin
      if (mode_q) begin
        advance = bus.mtrxReady;
      end else begin
        advance = (dwell_q == DwellLast);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      slot_q       <= idle_idx();
      dwell_q      <= '0;
      mode_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      // Abort beats any advance on the same edge, so a frame lost here is never counted.
      if (!bus.CPUvalid) begin
        state_q <= StIdle;
        slot_q  <= idle_idx();
        dwell_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StSend;
            slot_q  <= FirstIdx;
            dwell_q <= '0;
            mode_q  <= bus.mode;
          end
          StSend: begin
            if (advance) begin
              dwell_q <= '0;
              if (slot_q == LastIdx) begin
                state_q      <= StDone;
                slot_q       <= DoneIdx;
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + FCNT_W'(1);
              end else begin
                slot_q <= slot_q + slot_idx_t'(1);
              end
            end else if (!mode_q) begin
              dwell_q <= dwell_q + dwell_t'(1);
            end
          end
          StDone: begin
            if (bus.loop) begin
              state_q <= StSend;
              slot_q  <= FirstIdx;
              dwell_q <= '0;
              mode_q  <= bus.mode;
            end
          end
          default: begin
            state_q <= StIdle;
            slot_q  <= idle_idx();
            dwell_q <= '0;
          end
        endcase
      end
    end
  end

  mtrx_slot_mux #(
    .Width    (MTX_W),
    .Count    (N_MTX),
    .SelWidth (SlotW)
  ) u_slot_mux (
    .slots (bus.mtxIn),
    .sel   (slot_q),
    .en    (sending),
    .word  (bus.mtrxOut)
  );

  assign bus.matrixState = slot_q;
  assign bus.mtrxValid   = sending;
  assign bus.frameDone   = frame_done_q;
  assign bus.frameCnt    = frame_cnt_q;

endmodule

// File: tb/tb_mtrx_stream_seq.sv
// Bench: random and directed frames against a frame-position model, plus small-parameter corners.
`timescale 1ns / 100ps
module tb_mtrx_stream_seq;

  localparam int MW = 256;
  localparam int TN = 6;
  localparam int TD = 7;

  logic CLK;
  logic rst;

  int checks = 0;
  int errors = 0;

  mtrx_stream_seq_if #(.MTX_W(MW), .N_MTX(TN), .FCNT_W(16)) d_if ();
  mtrx_stream_seq_if #(.MTX_W(16), .N_MTX(3), .FCNT_W(4)) s_if ();
  mtrx_stream_seq_if #(.MTX_W(16), .N_MTX(1), .FCNT_W(8)) t_if ();

  mtrx_stream_seq #(.MTX_W(MW), .N_MTX(TN), .DWELL(TD), .FCNT_W(16)) u_dut (
    .CLK (CLK),
    .rst (rst),
    .bus (d_if)
  );

  mtrx_stream_seq #(.MTX_W(16), .N_MTX(3), .DWELL(2), .FCNT_W(4)) u_small (
    .CLK (CLK),
    .rst (rst),
    .bus (s_if)
  );

  mtrx_stream_seq #(.MTX_W(16), .N_MTX(1), .DWELL(1), .FCNT_W(8)) u_tiny (
    .CLK (CLK),
    .rst (rst),
    .bus (t_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Reference: a frame is a position (elapsed cycles or accepted words), not a state machine.
  bit m_run, m_done, m_mode, m_pulse;
  int m_t, m_acc, m_cnt;

  function automatic int exp_slot();
    if (!m_run) return 0;
    if (m_done) return TN + 1;
    if (!m_mode) return m_t / TD + 1;
    return m_acc + 1;
  endfunction

  task automatic model_step(input bit cv, input bit md, input bit lp, input bit rdy);
    m_pulse = 1'b0;
    if (!cv) begin
      m_run  = 1'b0;
      m_done = 1'b0;
    end else if (!m_run || (m_done && lp)) begin
      m_run  = 1'b1;
      m_done = 1'b0;
      m_mode = md;
      m_t    = 0;
      m_acc  = 0;
    end else if (!m_done) begin
      if (!m_mode) m_t++;
      else if (rdy) m_acc++;
      if ((!m_mode && m_t == TN * TD) || (m_mode && m_acc == TN)) begin
        m_done  = 1'b1;
        m_pulse = 1'b1;
        m_cnt   = (m_cnt + 1) % 65536;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_dut(input string tag);
    int            es;
    bit            ev;
    logic [MW-1:0] eo;
    es = exp_slot();
    ev = m_run && !m_done;
    eo = '0;
    if (ev) eo = d_if.mtxIn[(es-1)*MW +: MW];
    chk({tag, ".matrixState"}, 256'(d_if.matrixState), 256'(es));
    chk({tag, ".mtrxValid"},   256'(d_if.mtrxValid),   256'(ev));
    chk({tag, ".mtrxOut"},     256'(d_if.mtrxOut),     256'(eo));
    chk({tag, ".frameDone"},   256'(d_if.frameDone),   256'(m_pulse));
    chk({tag, ".frameCnt"},    256'(d_if.frameCnt),    256'(m_cnt));
  endtask

  task automatic tick(input string tag, input bit cv, input bit md, input bit lp, input bit rdy);
    d_if.CPUvalid  = cv;
    d_if.mode      = md;
    d_if.loop      = lp;
    d_if.mtrxReady = rdy;
    model_step(cv, md, lp, rdy);
    @(posedge CLK);
    @(negedge CLK);
    check_dut(tag);
  endtask

  task automatic randomize_words();
    for (int j = 0; j < TN * MW / 32; j++) d_if.mtxIn[j*32 +: 32] = $urandom();
  endtask

  bit   rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] small_seq [9] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd1, 4'd1};

  initial begin
    rst = 1'b0;
    m_run = 0; m_done = 0; m_mode = 0; m_pulse = 0; m_t = 0; m_acc = 0; m_cnt = 0;
    d_if.CPUvalid = 0; d_if.mode = 0; d_if.loop = 0; d_if.mtrxReady = 0;
    randomize_words();
    s_if.CPUvalid = 0; s_if.mode = 0; s_if.loop = 0; s_if.mtrxReady = 0;
    s_if.mtxIn = 48'hC333_B222_A111;
    t_if.CPUvalid = 0; t_if.mode = 0; t_if.loop = 0; t_if.mtrxReady = 0;
    t_if.mtxIn = 16'h5A5A;

    // Reset state while rst is held low.
    @(negedge CLK);
    chk("rst.matrixState", 256'(d_if.matrixState), 256'(0));
    chk("rst.mtrxValid",   256'(d_if.mtrxValid),   256'(0));
    chk("rst.mtrxOut",     256'(d_if.mtrxOut),     256'(0));
    chk("rst.frameDone",   256'(d_if.frameDone),   256'(0));
    chk("rst.frameCnt",    256'(d_if.frameCnt),    256'(0));
    rst = 1'b1;

    // Timed frame with defaults: DONE reached on cycle 43.
    for (int i = 0; i < 50; i++) begin
      tick("timed", 1'b1, 1'b0, 1'b0, 1'($urandom()));
      if (i == 42) begin
        chk("timed.done_state", 256'(d_if.matrixState), 256'(7));
        chk("timed.done_pulse", 256'(d_if.frameDone),   256'(1));
      end
    end
    chk("timed.cnt", 256'(d_if.frameCnt), 256'(1));

    // Handshake frame with ready pattern 1,0,0,1.
    tick("hs_abort", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick("hs", 1'b1, 1'b1, 1'b0, rdy_pat[i % 4]);
    chk("hs.cnt", 256'(d_if.frameCnt), 256'(2));

    // Mode toggled mid-frame must not change the current frame's pacing.
    tick("mt_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 46; i++)
      tick("mode_toggle", 1'b1, (i < 2) ? 1'b0 : 1'($urandom()), 1'b0, 1'($urandom()));
    tick("mt_abort2", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick("mode_next", 1'b1, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);

    // Abort while slot 3 is being sent, then restart.
    tick("ab_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ab_start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && exp_slot() != 3; i++) tick("ab_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ab_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.state", 256'(d_if.matrixState), 256'(0));
    chk("abort.out",   256'(d_if.mtrxOut),     256'(0));
    tick("ab_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort.restart", 256'(d_if.matrixState), 256'(1));

    // Abort coinciding with the final handshake: the frame is not counted.
    tick("fin_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("fin_start", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && exp_slot() != TN; i++) tick("fin_acc", 1'b1, 1'b1, 1'b0, 1'b1);
    tick("fin_drop", 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) randomize_words();
      tick("rand", $urandom_range(0, 24) != 0, 1'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    // Asynchronous reset pulse mid-frame between clock edges.
    tick("rs_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick("rs_run", 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #0.5;
    chk("arst.matrixState", 256'(d_if.matrixState), 256'(0));
    chk("arst.mtrxValid",   256'(d_if.mtrxValid),   256'(0));
    chk("arst.mtrxOut",     256'(d_if.mtrxOut),     256'(0));
    chk("arst.frameCnt",    256'(d_if.frameCnt),    256'(0));
    #0.5 rst = 1'b1;
    m_run = 0; m_done = 0; m_mode = 0; m_pulse = 0; m_cnt = 0;
    tick("rs_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arst.restart", 256'(d_if.matrixState), 256'(1));
    for (int i = 0; i < 5; i++) tick("rs_after", 1'b1, 1'b0, 1'b0, 1'b0);
    tick("end_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Looping timed frames with N_MTX=3, DWELL=2, 4-bit frame counter.
    s_if.CPUvalid = 1'b1;
    s_if.loop     = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("small.seq%0d", c), 256'(s_if.matrixState), 256'(small_seq[c-1]));
      chk($sformatf("small.fd%0d", c),  256'(s_if.frameDone),   256'(c == 7));
    end
    chk("small.out", 256'(s_if.mtrxOut), 256'(16'hA111));
    repeat (91) @(posedge CLK);
    @(negedge CLK);
    chk("small.cnt100", 256'(s_if.frameCnt), 256'(14));
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    chk("small.wrap", 256'(s_if.frameCnt), 256'(0));
    s_if.CPUvalid = 1'b0;

    // N_MTX=1, DWELL=1: one slot per cycle, looping.
    t_if.CPUvalid = 1'b1;
    t_if.loop     = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("tiny.state%0d", c), 256'(t_if.matrixState), 256'((c % 2 == 1) ? 1 : 2));
      chk($sformatf("tiny.valid%0d", c), 256'(t_if.mtrxValid),   256'(c % 2 == 1));
      chk($sformatf("tiny.out%0d", c),   256'(t_if.mtrxOut),     256'((c % 2 == 1) ? 16'h5A5A : 16'h0));
      chk($sformatf("tiny.cnt%0d", c),   256'(t_if.frameCnt),    256'(c / 2));
    end
    t_if.CPUvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
